// File: rtl/ddio_write_sequencer.sv
// Write-path burst sequencer feeding a DDIO pin stage: buffers double-width
// words in a small FIFO and frames fixed-length bursts with preamble/postamble.
module ddio_write_sequencer #(
   parameter int DATA_WIDTH       = 8,
   parameter int FIFO_DEPTH       = 4,
   parameter int BURST_LEN        = 4,
   parameter int PREAMBLE_CYCLES  = 1,
   parameter int POSTAMBLE_CYCLES = 1
) (
   input  logic                          outclk,
   input  logic                          areset,
   input  logic                          wr_start,
   output logic                          wr_busy,
   input  logic [2*DATA_WIDTH-1:0]       wdata,
   input  logic                          wdata_valid,
   output logic                          wdata_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [DATA_WIDTH-1:0]         datain_h,
   output logic [DATA_WIDTH-1:0]         datain_l,
   output logic                          oe,
   output logic                          underrun
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] LP_DEPTH     = LW'(FIFO_DEPTH);
   localparam logic [AW-1:0] LP_PTR_ONE   = AW'(32'd1);
   localparam logic          LP_HAS_PRE   = (PREAMBLE_CYCLES > 32'sd0);
   localparam logic          LP_HAS_POST  = (POSTAMBLE_CYCLES > 32'sd0);
   localparam logic [7:0]    LP_BEAT_LAST = 8'(BURST_LEN - 32'sd1);
   localparam logic [3:0]    LP_PRE_LAST  = LP_HAS_PRE  ? 4'(PREAMBLE_CYCLES - 32'sd1)  : 4'd0;
   localparam logic [3:0]    LP_POST_LAST = LP_HAS_POST ? 4'(POSTAMBLE_CYCLES - 32'sd1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PRE  = 2'd1,
      S_DATA = 2'd2,
      S_POST = 2'd3
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [7:0]              r_beat;
   logic [7:0]              w_beat_nxt;
   logic [3:0]              r_phase;
   logic [3:0]              w_phase_nxt;
   logic                    w_beat;

   logic [2*DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]           r_wr_ptr;
   logic [AW-1:0]           r_rd_ptr;
   logic [LW-1:0]           r_level;
   logic [LW-1:0]           w_level_nxt;
   logic                    r_wready;
   logic                    w_push;
   logic                    w_pop;
   logic [2*DATA_WIDTH-1:0] w_head;

   logic                    r_busy;
   logic                    r_oe;
   logic                    r_underrun;
   logic [DATA_WIDTH-1:0]   r_dh;
   logic [DATA_WIDTH-1:0]   r_dl;

   // w_beat marks that the cycle after this edge presents a data beat, so the pop happens here.
   assign w_push      = wdata_valid & r_wready;
   assign w_pop       = w_beat & (r_level != {LW{1'b0}});
   assign w_level_nxt = r_level + LW'(w_push) - LW'(w_pop);
   assign w_head      = r_mem[r_rd_ptr];

   // Next-state, counter and beat-load decode.
   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat;
      w_phase_nxt = r_phase;
      w_beat      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (wr_start) begin
               w_beat_nxt  = 8'd0;
               w_phase_nxt = 4'd0;
               if (LP_HAS_PRE) begin
                  w_state_nxt = S_PRE;
               end else begin
                  w_state_nxt = S_DATA;
                  w_beat      = 1'b1;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_PRE: begin
            if (r_phase == LP_PRE_LAST) begin
               w_state_nxt = S_DATA;
               w_beat_nxt  = 8'd0;
               w_beat      = 1'b1;
            end else begin
               w_phase_nxt = r_phase + 4'd1;
            end
         end
         S_DATA: begin
            if (r_beat == LP_BEAT_LAST) begin
               // A request on the final beat chains straight into the next burst.
               if (wr_start) begin
                  w_state_nxt = S_DATA;
                  w_beat_nxt  = 8'd0;
                  w_beat      = 1'b1;
               end else if (LP_HAS_POST) begin
                  w_state_nxt = S_POST;
                  w_phase_nxt = 4'd0;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_beat_nxt = r_beat + 8'd1;
               w_beat     = 1'b1;
            end
         end
         S_POST: begin
            if (r_phase == LP_POST_LAST) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_phase_nxt = r_phase + 4'd1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // FSM state and counters.
   always_ff @(posedge outclk or posedge areset) begin
      if (areset) begin
         r_state <= S_IDLE;
         r_beat  <= 8'd0;
         r_phase <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_beat  <= w_beat_nxt;
         r_phase <= w_phase_nxt;
      end
   end

   // FIFO storage; stale entries are never presented since pops require a non-empty FIFO.
   always_ff @(posedge outclk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= wdata;
      end
   end

   // FIFO pointers, occupancy and ready flag (ready reflects post-edge fullness).
   always_ff @(posedge outclk or posedge areset) begin
      if (areset) begin
         r_wr_ptr <= {AW{1'b0}};
         r_rd_ptr <= {AW{1'b0}};
         r_level  <= {LW{1'b0}};
         r_wready <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
         end
         r_level  <= w_level_nxt;
         r_wready <= (w_level_nxt != LP_DEPTH);
      end
   end

   // Registered pin-stage outputs.
   always_ff @(posedge outclk or posedge areset) begin
      if (areset) begin
         r_busy     <= 1'b0;
         r_oe       <= 1'b0;
         r_underrun <= 1'b0;
         r_dh       <= {DATA_WIDTH{1'b0}};
         r_dl       <= {DATA_WIDTH{1'b0}};
      end else begin
         r_busy     <= (w_state_nxt != S_IDLE);
         r_oe       <= (w_state_nxt != S_IDLE);
         r_underrun <= w_beat & ~w_pop;
         if (w_pop) begin
            r_dh <= w_head[2*DATA_WIDTH-1:DATA_WIDTH];
            r_dl <= w_head[DATA_WIDTH-1:0];
         end else begin
            r_dh <= {DATA_WIDTH{1'b0}};
            r_dl <= {DATA_WIDTH{1'b0}};
         end
      end
   end

   assign wr_busy     = r_busy;
   assign oe          = r_oe;
   assign underrun    = r_underrun;
   assign datain_h    = r_dh;
   assign datain_l    = r_dl;
   assign wdata_ready = r_wready;
   assign fifo_level  = r_level;

endmodule

// File: tb/tb_ddio_write_sequencer.sv
// Directed bench for ddio_write_sequencer: a default instance (P=1,B=4,Q=1)
// and a P=0,B=1,Q=0 instance, checked against hand-computed vectors.
module tb_ddio_write_sequencer;

   logic outclk = 1'b0;
   logic areset;
   always #5 outclk = ~outclk;

   logic        a_start, a_valid, a_busy, a_ready, a_oe, a_un;
   logic [15:0] a_wdata;
   logic [2:0]  a_level;
   logic [7:0]  a_h, a_l;

   logic        b_start, b_valid, b_busy, b_ready, b_oe, b_un;
   logic [15:0] b_wdata;
   logic [2:0]  b_level;
   logic [7:0]  b_h, b_l;

   ddio_write_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BURST_LEN(4),
                          .PREAMBLE_CYCLES(1), .POSTAMBLE_CYCLES(1)) u_dut_a (
      .outclk(outclk), .areset(areset), .wr_start(a_start), .wr_busy(a_busy),
      .wdata(a_wdata), .wdata_valid(a_valid), .wdata_ready(a_ready),
      .fifo_level(a_level), .datain_h(a_h), .datain_l(a_l), .oe(a_oe),
      .underrun(a_un));

   ddio_write_sequencer #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .BURST_LEN(1),
                          .PREAMBLE_CYCLES(0), .POSTAMBLE_CYCLES(0)) u_dut_b (
      .outclk(outclk), .areset(areset), .wr_start(b_start), .wr_busy(b_busy),
      .wdata(b_wdata), .wdata_valid(b_valid), .wdata_ready(b_ready),
      .fifo_level(b_level), .datain_h(b_h), .datain_l(b_l), .oe(b_oe),
      .underrun(b_un));

   typedef struct {
      logic        st;
      logic        v;
      logic [15:0] d;
      logic        oe;
      logic [7:0]  h;
      logic [7:0]  l;
      logic        un;
      logic [2:0]  lvl;
      logic        rdy;
   } vec_t;

   vec_t tbl [0:20];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge outclk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic oe_e, input logic [7:0] h_e,
                        input logic [7:0] l_e, input logic un_e);
      chk({tag, " oe"}, 32'(a_oe), 32'(oe_e));
      chk({tag, " busy"}, 32'(a_busy), 32'(oe_e));
      chk({tag, " h"}, 32'(a_h), 32'(h_e));
      chk({tag, " l"}, 32'(a_l), 32'(l_e));
      chk({tag, " underrun"}, 32'(a_un), 32'(un_e));
   endtask

   task automatic chk_fa(input string tag, input logic [2:0] lvl_e, input logic rdy_e);
      chk({tag, " level"}, 32'(a_level), 32'(lvl_e));
      chk({tag, " ready"}, 32'(a_ready), 32'(rdy_e));
   endtask

   task automatic chk_b(input string tag, input logic oe_e, input logic [7:0] h_e,
                        input logic [7:0] l_e, input logic un_e, input logic [2:0] lvl_e);
      chk({tag, " oe"}, 32'(b_oe), 32'(oe_e));
      chk({tag, " busy"}, 32'(b_busy), 32'(oe_e));
      chk({tag, " h"}, 32'(b_h), 32'(h_e));
      chk({tag, " l"}, 32'(b_l), 32'(l_e));
      chk({tag, " underrun"}, 32'(b_un), 32'(un_e));
      chk({tag, " level"}, 32'(b_level), 32'(lvl_e));
   endtask

   function automatic vec_t mk(input logic st, input logic v, input logic [15:0] d,
                               input logic oe_e, input logic [7:0] h, input logic [7:0] l,
                               input logic un, input logic [2:0] lvl, input logic rdy);
      vec_t t;
      t.st = st; t.v = v; t.d = d; t.oe = oe_e; t.h = h; t.l = l;
      t.un = un; t.lvl = lvl; t.rdy = rdy;
      return t;
   endfunction

   task automatic run_tbl(input int first, input int last, input string pfx);
      for (int i = first; i <= last; i++) begin
         a_start = tbl[i].st;
         a_valid = tbl[i].v;
         a_wdata = tbl[i].d;
         step();
         chk_a($sformatf("%s%0d", pfx, i), tbl[i].oe, tbl[i].h, tbl[i].l, tbl[i].un);
         chk_fa($sformatf("%s%0d", pfx, i), tbl[i].lvl, tbl[i].rdy);
      end
      a_start = 1'b0;
      a_valid = 1'b0;
   endtask

   function automatic logic [15:0] bw(input int i);
      return 16'h1080 + 16'(i * 257);
   endfunction

   initial begin
      int          n;
      logic        rdy_before;
      logic        exp_oe;
      logic [15:0] exp_d;
      logic [15:0] fw [0:4];

      fw[0] = 16'hE101; fw[1] = 16'hE202; fw[2] = 16'hE303;
      fw[3] = 16'hE404; fw[4] = 16'hE505;

      // Basic burst: preload A1B1..A4B4, start, P=1 B=4 Q=1; wr_start in a non-final beat is ignored.
      tbl[0]  = mk(1'b0, 1'b1, 16'hA1B1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1);
      tbl[1]  = mk(1'b0, 1'b1, 16'hA2B2, 1'b0, 8'h00, 8'h00, 1'b0, 3'd2, 1'b1);
      tbl[2]  = mk(1'b0, 1'b1, 16'hA3B3, 1'b0, 8'h00, 8'h00, 1'b0, 3'd3, 1'b1);
      tbl[3]  = mk(1'b0, 1'b1, 16'hA4B4, 1'b0, 8'h00, 8'h00, 1'b0, 3'd4, 1'b0);
      tbl[4]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 3'd4, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'hA1, 8'hB1, 1'b0, 3'd3, 1'b1);
      tbl[6]  = mk(1'b1, 1'b0, 16'h0000, 1'b1, 8'hA2, 8'hB2, 1'b0, 3'd2, 1'b1);
      tbl[7]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'hA3, 8'hB3, 1'b0, 3'd1, 1'b1);
      tbl[8]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'hA4, 8'hB4, 1'b0, 3'd0, 1'b1);
      tbl[9]  = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
      tbl[10] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
      // Underrun: two words for a four-beat burst; wr_start in PRE and POST is ignored.
      tbl[11] = mk(1'b0, 1'b1, 16'hC1D1, 1'b0, 8'h00, 8'h00, 1'b0, 3'd1, 1'b1);
      tbl[12] = mk(1'b0, 1'b1, 16'hC2D2, 1'b0, 8'h00, 8'h00, 1'b0, 3'd2, 1'b1);
      tbl[13] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 3'd2, 1'b1);
      tbl[14] = mk(1'b1, 1'b0, 16'h0000, 1'b1, 8'hC1, 8'hD1, 1'b0, 3'd1, 1'b1);
      tbl[15] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'hC2, 8'hD2, 1'b0, 3'd0, 1'b1);
      tbl[16] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1);
      tbl[17] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1);
      tbl[18] = mk(1'b0, 1'b0, 16'h0000, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
      tbl[19] = mk(1'b1, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);
      tbl[20] = mk(1'b0, 1'b0, 16'h0000, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 1'b1);

      areset  = 1'b1;
      a_start = 1'b0; a_valid = 1'b0; a_wdata = 16'h0000;
      b_start = 1'b0; b_valid = 1'b0; b_wdata = 16'h0000;
      repeat (2) @(posedge outclk);
      #1;
      chk_a("reset", 1'b0, 8'h00, 8'h00, 1'b0);
      chk_fa("reset", 3'd0, 1'b0);
      chk("reset b ready", 32'(b_ready), 32'd0);
      @(negedge outclk);
      areset = 1'b0;
      step();
      chk_fa("release", 3'd0, 1'b1);

      run_tbl(0, 20, "vec");

      // Back-to-back: 4 preloaded, 4 streamed in while the burst runs, chained on the last beat.
      for (int i = 0; i < 4; i++) begin
         a_valid = 1'b1;
         a_wdata = bw(i);
         step();
      end
      chk_fa("b2b preload", 3'd4, 1'b0);
      n = 4;
      for (int c = 0; c <= 10; c++) begin
         a_start    = (c == 0 || c == 5);
         a_valid    = (n < 8);
         a_wdata    = (n < 8) ? bw(n) : 16'h0000;
         rdy_before = a_ready;
         step();
         if (a_valid && rdy_before) n++;
         exp_oe = (c <= 9);
         exp_d  = (c >= 1 && c <= 8) ? bw(c - 1) : 16'h0000;
         chk_a($sformatf("b2b c%0d", c), exp_oe, exp_d[15:8], exp_d[7:0], 1'b0);
      end
      a_start = 1'b0;
      a_valid = 1'b0;
      chk_fa("b2b end", 3'd0, 1'b1);

      // FIFO full: five pushes with valid held; the fifth lands only after the first pop.
      a_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_wdata = fw[i];
         step();
         chk_fa($sformatf("full push%0d", i), 3'(i + 1), (i < 3));
      end
      a_wdata = fw[4];
      step();
      chk_fa("full hold", 3'd4, 1'b0);
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      chk_fa("full pre", 3'd4, 1'b0);
      step();
      chk_a("full beat0", 1'b1, 8'hE1, 8'h01, 1'b0);
      chk_fa("full beat0", 3'd3, 1'b1);
      step();
      a_valid = 1'b0;
      chk_a("full beat1", 1'b1, 8'hE2, 8'h02, 1'b0);
      chk_fa("full beat1", 3'd3, 1'b1);
      repeat (4) step();
      chk_a("full idle", 1'b0, 8'h00, 8'h00, 1'b0);
      chk_fa("full idle", 3'd1, 1'b1);

      // Reset mid-burst: fifth word is beat 0, beat 1 underruns, then areset asserts asynchronously.
      a_start = 1'b1;
      step();
      a_start = 1'b0;
      step();
      chk_a("rst beat0", 1'b1, 8'hE5, 8'h05, 1'b0);
      step();
      chk_a("rst beat1", 1'b1, 8'h00, 8'h00, 1'b1);
      #2;
      areset = 1'b1;
      #1;
      chk_a("rst async", 1'b0, 8'h00, 8'h00, 1'b0);
      chk_fa("rst async", 3'd0, 1'b0);
      @(posedge outclk);
      @(negedge outclk);
      areset = 1'b0;
      step();
      chk_a("rst release", 1'b0, 8'h00, 8'h00, 1'b0);
      chk_fa("rst release", 3'd0, 1'b1);
      run_tbl(0, 10, "post-reset vec");

      // Zero pre/postamble instance: single beat, then chaining and a chained underrun.
      b_valid = 1'b1;
      b_wdata = 16'h5AA5;
      step();
      b_valid = 1'b0;
      chk_b("b push", 1'b0, 8'h00, 8'h00, 1'b0, 3'd1);
      b_start = 1'b1;
      step();
      b_start = 1'b0;
      chk_b("b beat", 1'b1, 8'h5A, 8'hA5, 1'b0, 3'd0);
      step();
      chk_b("b idle", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);
      b_valid = 1'b1;
      b_wdata = 16'h1122;
      step();
      b_wdata = 16'h3344;
      step();
      b_valid = 1'b0;
      b_start = 1'b1;
      step();
      chk_b("b chain0", 1'b1, 8'h11, 8'h22, 1'b0, 3'd1);
      step();
      chk_b("b chain1", 1'b1, 8'h33, 8'h44, 1'b0, 3'd0);
      step();
      b_start = 1'b0;
      chk_b("b chain2", 1'b1, 8'h00, 8'h00, 1'b1, 3'd0);
      step();
      chk_b("b end", 1'b0, 8'h00, 8'h00, 1'b0, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
